sobel_window_gen: RTL

SOBEL_WINDOW_GEN -- requirements
Module: sobel_window_gen

---
 rtl/sobel_window_gen.sv | 74 +++++++
 1 files changed

// File: rtl/sobel_window_gen.sv
// sobel_window_gen: streams raster pixels into 3x3 neighbourhood windows for a Sobel stage.
module sobel_window_gen #(
  parameter int SRC_ROWS = 147,
  parameter int SRC_COLS = 143
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] pix_in,
  input  logic       pix_valid,
  output logic       pix_ready,
  output logic [7:0] z1,
  output logic [7:0] z2,
  output logic [7:0] z3,
  output logic [7:0] z4,
  output logic [7:0] z6,
  output logic [7:0] z7,
  output logic [7:0] z8,
  output logic [7:0] z9,
  output logic       win_valid,
  input  logic       win_ready,
  output logic       win_last,
  output logic       frame_done
);
  localparam int RW = $clog2(SRC_ROWS);
  localparam int CW = $clog2(SRC_COLS);
  localparam logic [RW-1:0] R_END = RW'(SRC_ROWS - 1);
  localparam logic [CW-1:0] C_END = CW'(SRC_COLS - 1);
  logic [RW-1:0] r;
  logic [CW-1:0] c;
  logic [7:0] lb1 [SRC_COLS];
  logic [7:0] lb2 [SRC_COLS];
  logic [1:0][7:0] t0, t1, t2;
  logic [7:0] a1, a2;
  logic acc, prod, c_end, r_end;
  assign pix_ready = !win_valid || win_ready;
  assign acc = pix_valid && pix_ready;
  assign c_end = c == C_END;
  assign r_end = r == R_END;
  assign prod = acc && r > RW'(1) && c > CW'(1);
  assign a1 = lb1[c];
  assign a2 = lb2[c];
  // Index 0 of each tap pair holds column c-1, index 1 holds column c-2; column c comes live.
  always_ff @(posedge clk)
    if (acc) begin
      lb2[c] <= a1;
      lb1[c] <= pix_in;
      t0 <= {t0[0], pix_in};
      t1 <= {t1[0], a1};
      t2 <= {t2[0], a2};
    end
  always_ff @(posedge clk)
    if (!reset) begin
      r <= '0;
      c <= '0;
      win_valid <= 1'b0;
      win_last <= 1'b0;
      frame_done <= 1'b0;
      {z1, z2, z3, z4, z6, z7, z8, z9} <= '0;
    end else begin
      frame_done <= win_valid && win_ready && win_last;
      if (acc) begin
        c <= c_end ? '0 : c + 1'b1;
        r <= c_end ? (r_end ? '0 : r + 1'b1) : r;
      end
      if (prod) begin
        {z1, z2, z3, z4, z6, z7, z8, z9} <= {t2[1], t2[0], a2, t1[1], a1, t0[1], t0[0], pix_in};
        win_valid <= 1'b1;
        win_last <= r_end && c_end;
      end else if (win_ready) begin
        win_valid <= 1'b0;
        win_last <= 1'b0;
      end
    end
endmodule
